// File: rtl/mac_pkg.sv
// Shared definitions for the 14x14 saturating MAC and its downstream result FIFO.
package mac_pkg;

   localparam int MAC_IN_W    = 14;
   localparam int MAC_OUT_W   = 28;
   localparam int MAC_LATENCY = 2;

   typedef logic signed [MAC_OUT_W-1:0] mac_result_t;

endpackage : mac_pkg

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and occupancy bookkeeping for the MAC result FIFO.
// Owns the read/write pointers and the count, and decides whether a write or
// read actually happens this cycle. Storage lives in the parent.
module fifo_ptr_ctrl #(
   parameter  int DEPTH = 8,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_writeReq,
   input  logic          i_readReady,
   output logic          o_wr,
   output logic          o_rd,
   output logic          o_full,
   output logic          o_empty,
   output logic [PW-1:0] o_wrPtr,
   output logic [PW-1:0] o_rdPtr,
   output logic [CW-1:0] o_count
);

   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] r_rdPtr;
   logic [CW-1:0] r_count;

   logic w_full;
   logic w_empty;
   logic w_rd;
   logic w_wr;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);

   // A read needs a valid head, which is exactly "not empty". A write into a
   // full FIFO is still accepted when the same cycle's read frees a slot.
   assign w_rd = !w_empty && i_readReady;
   assign w_wr = i_writeReq && (!w_full || w_rd);

   // Pointers wrap naturally modulo DEPTH because DEPTH is a power of two;
   // the count moves by +1, -1 or not at all depending on the wr/rd pair.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_rd) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         if (w_wr && !w_rd) begin
            r_count <= r_count + CW'(1);
         end else if (w_rd && !w_wr) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   assign o_wr    = w_wr;
   assign o_rd    = w_rd;
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_wrPtr = r_wrPtr;
   assign o_rdPtr = r_rdPtr;
   assign o_count = r_count;

endmodule : fifo_ptr_ctrl

// File: rtl/mac_result_fifo.sv
// Result buffer behind the 14x14 saturating MAC.
// Captures each accumulator result on the MAC's valid strobe, queues it in a
// circular buffer and hands it to a consumer over valid/ready. Because the MAC
// cannot be stalled and has results in flight, a credit (ready_up) is exported
// that keeps SKID entries free for results already inside the MAC pipeline.
module mac_result_fifo
   import mac_pkg::*;
#(
   parameter  int DATA_W = MAC_OUT_W,
   parameter  int DEPTH  = 8,
   parameter  int SKID   = MAC_LATENCY,
   localparam int PW     = $clog2(DEPTH),
   localparam int CW     = PW + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] f_in,
   input  logic                     valid_in,
   output logic                     ready_up,
   output logic signed [DATA_W-1:0] dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic [CW-1:0]            count,
   output logic                     overflow,
   input  logic                     ovf_clr
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              r_overflow;

   logic          w_wr;
   logic          w_rd;
   logic          w_full;
   logic          w_empty;
   logic          w_drop;
   logic [PW-1:0] w_wrPtr;
   logic [PW-1:0] w_rdPtr;
   logic [CW-1:0] w_count;

   fifo_ptr_ctrl #(
      .DEPTH (DEPTH)
   ) u_ptrCtrl (
      .clk         (clk),
      .reset       (reset),
      .i_writeReq  (valid_in),
      .i_readReady (dout_ready),
      .o_wr        (w_wr),
      .o_rd        (w_rd),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_wrPtr     (w_wrPtr),
      .o_rdPtr     (w_rdPtr),
      .o_count     (w_count)
   );

   // Storage is deliberately left unreset; occupancy alone decides what is
   // visible, so stale contents can never reach dout.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[w_wrPtr] <= f_in;
      end
   end

   // A result arriving with no room and no simultaneous pop is lost.
   assign w_drop = valid_in && w_full && !w_rd;

   // Sticky drop flag; a drop in the same cycle as a clear keeps it set so
   // the loss is never silently hidden.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (ovf_clr) begin
         r_overflow <= 1'b0;
      end
   end

   // Head of queue is a plain registered-array read, so a write only becomes
   // visible the cycle after it lands; empty forces zero on dout.
   assign dout       = w_empty ? '0 : $signed(r_mem[w_rdPtr]);
   assign dout_valid = !w_empty;

   // Credit: free slots must exceed the results that may still be in flight.
   assign ready_up = (w_count < CW'(DEPTH - SKID));

   assign count    = w_count;
   assign overflow = r_overflow;

endmodule : mac_result_fifo

// File: tb/tb_mac_result_fifo.sv
// Directed bench for mac_result_fifo: hand-computed vectors checked with
// immediate assertions, plus a small queue model for the wrapping stream.
module tb_mac_result_fifo;

   localparam int DATA_W = 28;
   localparam int DEPTH  = 8;
   localparam int SKID   = 2;

   logic              clk;
   logic              reset;
   logic [DATA_W-1:0] f_in;
   logic              valid_in;
   logic              ready_up;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;
   logic [3:0]        count;
   logic              overflow;
   logic              ovf_clr;

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] modelQ [$];

   mac_result_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .SKID   (SKID)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .f_in       (f_in),
      .valid_in   (valid_in),
      .ready_up   (ready_up),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .count      (count),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle just past it before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive all data-path inputs at once.
   task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                                input logic rdy, input logic clr);
      valid_in   = v;
      f_in       = d;
      dout_ready = rdy;
      ovf_clr    = clr;
   endtask

   // One comparison: counted, and reported on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Directed sequence covering reset, fill/drain, drop, credit and wrap.
   initial begin
      int issued;
      int cyc;
      logic expRd;
      logic expWr;

      reset = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      checkOutput("rst_count", count, 0);
      checkOutput("rst_dout_valid", dout_valid, 0);
      checkOutput("rst_dout", dout, 0);
      checkOutput("rst_ready_up", ready_up, 1);
      checkOutput("rst_overflow", overflow, 0);

      // Single write appears on the following cycle.
      applyStimulus(1'b1, 28'h0000005, 1'b0, 1'b0);
      checkOutput("no_fallthrough", dout_valid, 0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("single_dout_valid", dout_valid, 1);
      checkOutput("single_dout", dout, 5);
      checkOutput("single_count", count, 1);
      tick();
      checkOutput("single_stable", dout, 5);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("single_drained", count, 0);

      // Fill 1..8 with the consumer stalled; credit drops at count 6.
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, DATA_W'(i), 1'b0, 1'b0);
         tick();
         checkOutput($sformatf("fill_count_%0d", i), count, i);
         checkOutput($sformatf("fill_ready_up_%0d", i), ready_up, (i < 6) ? 1 : 0);
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("fill_overflow", overflow, 0);

      // Drain in order.
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         checkOutput($sformatf("drain_dout_%0d", i), dout, i);
         tick();
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("drain_dout_valid", dout_valid, 0);
      checkOutput("drain_dout", dout, 0);

      // Refill with 11..18 for the full-FIFO cases.
      for (int i = 11; i <= 18; i++) begin
         applyStimulus(1'b1, DATA_W'(i), 1'b0, 1'b0);
         tick();
      end
      checkOutput("refill_count", count, 8);

      // Write into full FIFO with no pop is dropped.
      applyStimulus(1'b1, 28'd99, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("drop_overflow", overflow, 1);
      checkOutput("drop_count", count, 8);
      checkOutput("drop_head", dout, 11);

      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("ovf_clr", overflow, 0);

      // Drop and clear in the same cycle: drop wins.
      applyStimulus(1'b1, 28'd99, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("drop_beats_clr", overflow, 1);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("ovf_clr_again", overflow, 0);

      // Full FIFO with simultaneous pop accepts the new value.
      applyStimulus(1'b1, 28'd42, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("fullrw_count", count, 8);
      checkOutput("fullrw_overflow", overflow, 0);
      checkOutput("fullrw_head", dout, 12);

      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      for (int i = 12; i <= 19; i++) begin
         checkOutput($sformatf("fullrw_drain_%0d", i), dout, (i == 19) ? 42 : i);
         tick();
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("fullrw_empty", dout_valid, 0);

      // Stream 20 values through the wrap with a credit-honouring feeder and
      // a consumer toggling ready every cycle.
      modelQ.delete();
      issued = 0;
      cyc    = 0;
      while ((issued < 20 || modelQ.size() > 0) && cyc < 200) begin
         checkOutput("wrap_count", count, modelQ.size());
         checkOutput("wrap_ready_up", ready_up, ((DEPTH - modelQ.size()) > SKID) ? 1 : 0);
         if (modelQ.size() > 0) begin
            checkOutput("wrap_dout", dout, modelQ[0]);
         end
         applyStimulus((issued < 20) && ((DEPTH - modelQ.size()) > SKID),
                       DATA_W'(32'h100 + issued), cyc[0], 1'b0);
         expRd = (modelQ.size() > 0) && dout_ready;
         expWr = valid_in && ((modelQ.size() < DEPTH) || expRd);
         if (expRd) begin
            void'(modelQ.pop_front());
         end
         if (expWr) begin
            modelQ.push_back(f_in);
            issued++;
         end
         tick();
         cyc++;
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("wrap_all_issued", issued, 20);
      checkOutput("wrap_finished", (cyc < 200) ? 1 : 0, 1);
      checkOutput("wrap_overflow", overflow, 0);
      checkOutput("wrap_final_count", count, 0);

      // Reset mid-burst with five entries stored and a write pending.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, DATA_W'(30 + i), 1'b0, 1'b0);
         tick();
      end
      checkOutput("prerst_count", count, 5);
      reset = 1'b1;
      applyStimulus(1'b1, 28'd77, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("midrst_count", count, 0);
      checkOutput("midrst_dout_valid", dout_valid, 0);
      checkOutput("midrst_dout", dout, 0);
      checkOutput("midrst_ready_up", ready_up, 1);
      tick();
      checkOutput("midrst_not_stored", count, 0);

      // Extreme signed values pass through bit-exact.
      applyStimulus(1'b1, 28'h7ffffff, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 28'h8000000, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("bound_max", dout, 32'h7ffffff);
      tick();
      checkOutput("bound_min", dout, 32'h8000000);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("bound_empty", dout_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mac_result_fifo

// File: doc/mac_result_fifo.md
Name: mac_result_fifo

Overview:
- Downstream stage of the 14x14 saturating MAC.
- Captures each 28-bit signed accumulator result on the cycle the MAC asserts its output-valid strobe.
- Buffers results in a circular FIFO and presents them to a consumer over a valid/ready handshake.
- The MAC has no backpressure and its valid path has 2 cycles in flight. The block therefore exports a credit signal (ready_up) that tells the MAC's feeder when it may issue another valid_in.

Parameters:
- DATA_W, 28, result width; matches MAC accumulator width.
- DEPTH, 8, FIFO entries; power of 2, minimum 4.
- SKID, 2, MAC input-to-output latency; free entries reserved for in-flight results.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- f_in  input  DATA_W  signed MAC result (MAC f output).
- valid_in  input  1  MAC valid_out; write request for f_in.
- ready_up  output  1  high = feeder may assert MAC valid_in this cycle.
- dout  output  DATA_W  signed head-of-FIFO result.
- dout_valid  output  1  dout holds a valid entry.
- dout_ready  input  1  consumer accepts dout this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; a result was dropped.
- ovf_clr  input  1  clears overflow.

Behaviour:
- Reset (synchronous, active-high): wr_ptr=0, rd_ptr=0, count=0, overflow=0. Outputs: dout_valid=0, dout=0, ready_up=1. Memory contents are don't-care. Reset dominates all other inputs in the same cycle, including mid-burst, and discards stored data.
- Pointers: $clog2(DEPTH) bits each; wrap modulo DEPTH with no special case at the wrap.
- Signal definitions:
  - full = (count==DEPTH); empty = (count==0).
  - rd = dout_valid && dout_ready.
  - wr = valid_in && (!full || rd).
- On wr: mem[wr_ptr]<=f_in, wr_ptr++.
- On rd: rd_ptr++.
- count update: count += wr - rd.
- Simultaneous read and write:
  - When full: the read frees the slot; the write is accepted; count stays DEPTH.
  - When empty: no read is possible (dout_valid=0); the write is accepted; count becomes 1.
- Write latency: a write into an empty FIFO gives dout_valid=1 on the following cycle. There is no combinational fall-through from f_in to dout.
- dout: combinational read of mem[rd_ptr] when count>0, otherwise 0. dout_valid = (count>0).
- Consumer rule: while dout_valid && !dout_ready, dout must stay stable across cycles.
- Drop: if valid_in && full && !rd, f_in is discarded, pointers are unchanged, and overflow<=1 on the next edge.
- ovf_clr: clears overflow; a drop in the same cycle wins, so overflow stays 1.
- Credit: ready_up = ((DEPTH - count) > SKID), combinational from registered count.
  - With DEPTH=8 and SKID=2, ready_up falls when count reaches 6.
  - A feeder honouring ready_up can never cause overflow, even with dout_ready held low.
- Data handling:
  - Data is stored bit-exact.
  - No saturation or sign handling is done here; values 28'h7ffffff and 28'h8000000 pass through unchanged.
- No FSM beyond pointer and counter state.

Decomposition:
- Shared package mac_pkg:
  - localparams MAC_IN_W=14, MAC_OUT_W=28, MAC_LATENCY=2.
  - typedef logic signed [MAC_OUT_W-1:0] mac_result_t.
  - The MAC and this FIFO both use it; SKID defaults to MAC_LATENCY.
- One natural sub-module: fifo_ptr_ctrl.
  - Owns wr_ptr, rd_ptr and count.
  - Generates wr, rd, full and empty.
  - The top level keeps the storage array, dout mux, overflow flag and ready_up.

Test Plan:
- Reset, then valid_in=1 with f_in=28'h0000005, dout_ready=0 -> next cycle dout_valid=1, dout=5, count=1.
- Fill 8 writes (values 1..8), dout_ready=0 -> count=8; ready_up falls the cycle count becomes 6; no overflow. Then dout_ready=1 for 8 cycles -> dout reads 1..8 in order, then dout_valid=0.
- Full FIFO with valid_in=1, f_in=99, dout_ready=0 -> 99 dropped, overflow=1, count=8. Then ovf_clr=1 -> overflow=0 next cycle.
- Full FIFO, valid_in=1 (f_in=42) with dout_ready=1 -> head popped, 42 accepted, count stays 8, overflow stays 0; 42 emerges last.
- Pointer wrap: stream 20 values, valid_in every cycle, with dout_ready toggling 1/0 -> output order matches input exactly; count never exceeds DEPTH.
- Reset asserted with count=5 and valid_in=1 -> next cycle count=0, dout_valid=0, dout=0, ready_up=1, and the incoming value is not stored.
- Boundary values 28'h7ffffff and 28'h8000000 -> read back bit-exact.
